// File: rtl/ctrl_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_types_pkg : shared sub-FSM state encodings and sizing helpers         |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    LOOKUP_ST_IDLE = 2'd0,
    LOOKUP_ST_SCAN = 2'd1,
    LOOKUP_ST_DONE = 2'd2
  } lookup_substate_e;

  // A single-group cache still needs a 1-bit pointer to stay a legal vector.
  function automatic int lookup_ptr_width(input int groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_match_group.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_match_group : compares one group of LANES keys, lowest-lane one-hot    |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module key_match_group #(
  parameter int LANES     = 4,
  parameter int KEY_WIDTH = 16
) (
  input  logic [LANES*KEY_WIDTH-1:0] keys_i,
  input  logic [LANES-1:0]           used_i,
  input  logic [KEY_WIDTH-1:0]       key_i,
  output logic                       match_o,
  output logic [LANES-1:0]           onehot_o
);

  logic [LANES-1:0] lane_hit;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_hit[l] = used_i[l] && (keys_i[l*KEY_WIDTH +: KEY_WIDTH] == key_i);
    end
  endgenerate

  assign match_o  = |lane_hit;
  // Isolate the lowest set bit so the result stays one-hot with multiple hits.
  assign onehot_o = lane_hit & (~lane_hit + LANES'(1));

endmodule
`default_nettype wire

// File: rtl/key_lookup_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_lookup_fsm : group-serial key search over a cache tag array            |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module key_lookup_fsm
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 16,
  parameter int LANES       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [KEY_WIDTH-1:0]             key_in,
  input  logic [NUM_ENTRIES*KEY_WIDTH-1:0] keys_flat,
  input  logic [NUM_ENTRIES-1:0]           used,
  output logic                             busy,
  output logic                             done,
  output logic                             hit,
  output logic [NUM_ENTRIES-1:0]           idx_out
);

  localparam int GROUPS     = NUM_ENTRIES / LANES;
  localparam int PTR_W      = lookup_ptr_width(GROUPS);
  localparam int GROUP_BITS = LANES * KEY_WIDTH;
  localparam logic [PTR_W-1:0] LAST_GROUP = PTR_W'(GROUPS - 1);

  lookup_substate_e         state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [KEY_WIDTH-1:0]     key_q, key_d;
  logic                     hit_q, hit_d;
  logic [NUM_ENTRIES-1:0]   idx_q, idx_d;
  logic                     busy_q, done_q;

  logic [GROUP_BITS-1:0]    grp_keys;
  logic [LANES-1:0]         grp_used;
  logic [LANES-1:0]         grp_onehot;
  logic                     grp_match;
  logic [NUM_ENTRIES-1:0]   grp_idx;

  always_comb begin
    grp_keys = '0;
    grp_used = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (ptr_q == PTR_W'(g)) begin
        grp_keys = keys_flat[g*GROUP_BITS +: GROUP_BITS];
        grp_used = used[g*LANES +: LANES];
      end
    end
  end

  key_match_group #(
    .LANES     (LANES),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_match (
    .keys_i   (grp_keys),
    .used_i   (grp_used),
    .key_i    (key_q),
    .match_o  (grp_match),
    .onehot_o (grp_onehot)
  );

  // Place the group-local one-hot back at the group's position in the full index.
  always_comb begin
    grp_idx = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (ptr_q == PTR_W'(g)) begin
        grp_idx[g*LANES +: LANES] = grp_onehot;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    key_d   = key_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    if (abort) begin
      state_d = LOOKUP_ST_IDLE;
      hit_d   = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOOKUP_ST_IDLE: begin
          if (start) begin
            state_d = LOOKUP_ST_SCAN;
            key_d   = key_in;
            ptr_d   = '0;
            hit_d   = 1'b0;
            idx_d   = '0;
          end
        end
        LOOKUP_ST_SCAN: begin
          if (grp_match) begin
            state_d = LOOKUP_ST_DONE;
            hit_d   = 1'b1;
            idx_d   = grp_idx;
          end else if (ptr_q == LAST_GROUP) begin
            state_d = LOOKUP_ST_DONE;
            hit_d   = 1'b0;
            idx_d   = '0;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
        LOOKUP_ST_DONE: state_d = LOOKUP_ST_IDLE;
        default:        state_d = LOOKUP_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOOKUP_ST_IDLE;
      ptr_q   <= '0;
      key_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == LOOKUP_ST_SCAN);
      done_q  <= (state_d == LOOKUP_ST_DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hit     = hit_q;
  assign idx_out = idx_q;

endmodule
`default_nettype wire

// File: doc/key_lookup_fsm.md
KEY_LOOKUP_FSM -- requirements
Module: key_lookup_fsm

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, number of cache entries.
REQ-002 SHALL have parameter KEY_WIDTH, default 16, key width in bits.
REQ-003 SHALL have parameter LANES, default 4, entries compared per cycle; NUM_ENTRIES SHALL be a multiple of LANES.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request a lookup of key_in; sampled only in IDLE.
REQ-007 abort  input  1  cancel the current lookup.
REQ-008 key_in  input  KEY_WIDTH  key to search, captured on the accepted start.
REQ-009 keys_flat  input  NUM_ENTRIES*KEY_WIDTH  stored keys; entry i occupies bits [i*KEY_WIDTH +: KEY_WIDTH].
REQ-010 used  input  NUM_ENTRIES  per-entry valid bits.
REQ-011 busy  output  1  high while in SCAN.
REQ-012 done  output  1  single-cycle pulse when the result is valid.
REQ-013 hit  output  1  result: key found in a used entry.
REQ-014 idx_out  output  NUM_ENTRIES  one-hot index of the matching entry; all-zero on a miss.

Function
REQ-015 SHALL implement states LOOKUP_ST_IDLE, LOOKUP_ST_SCAN and LOOKUP_ST_DONE.
REQ-016 IDLE: start=1 and abort=0 SHALL latch key_in, clear the group pointer to 0 and move to SCAN next cycle; all other inputs are ignored.
REQ-017 SCAN: each cycle SHALL compare the latched key against group g (entries g*LANES .. g*LANES+LANES-1), counting only entries with used=1.
REQ-018 SCAN, match in group g: SHALL register hit=1 and idx_out=one-hot of the lowest-index matching entry in that group, then move to DONE.
REQ-019 SCAN, no match and g is the last group: SHALL register hit=0 and idx_out=0, then move to DONE.
REQ-020 SCAN, no match and g is not the last group: SHALL increment g and remain in SCAN.
REQ-021 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Latency: with start accepted at cycle 0, a match in group g SHALL give done at cycle g+2; a miss SHALL give done at cycle NUM_ENTRIES/LANES+1.
REQ-023 hit and idx_out SHALL hold their values from DONE until the next accepted start or abort; both SHALL be cleared on an accepted start.
REQ-024 start while in SCAN or DONE SHALL be ignored, with no queuing.
REQ-025 abort in any state SHALL force IDLE on the next edge, clear hit and idx_out, and suppress done; abort has priority over start and over a match in the same cycle.
REQ-026 keys_flat and used SHALL be held stable by the requester from start to done; the result is undefined otherwise.
REQ-027 The group-pointer width SHALL be max(1, clog2(NUM_ENTRIES/LANES)); the pointer never wraps inside one lookup.
REQ-028 idx_out SHALL never have more than one bit set.
REQ-029 hit and idx_out SHALL be wired directly to the hit and idx_in inputs of the downstream upsert stage; used SHALL be shared with that stage.

Reset
REQ-030 On rst_n=0: state=IDLE, busy=0, done=0, hit=0, idx_out=0, pointer=0, latched key=0.
REQ-031 Reset asserted mid-SCAN SHALL abandon the lookup; no done pulse SHALL follow reset release.

Structure
REQ-032 lookup_substate_e SHALL be added to ctrl_types_pkg alongside the existing sub-FSM state enums.
REQ-033 One sub-module, key_match_group: combinational; inputs are LANES keys, LANES used bits and the search key; outputs are a match flag and a LANES-wide lowest-match one-hot.
REQ-034 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (NUM_ENTRIES=16, KEY_WIDTH=16, LANES=4, start accepted at cycle 0)
REQ-035 Entry 5 = 0xBEEF, used, key_in=0xBEEF -> done at cycle 3, hit=1, idx_out=0x0020, busy high in cycles 1-2.
REQ-036 All 16 entries used, none equal to 0x1234, key_in=0x1234 -> done at cycle 5, hit=0, idx_out=0x0000.
REQ-037 Entries 2 and 9 = 0xAAAA, both used -> done at cycle 2, idx_out=0x0004; entries 1 and 3 matching -> idx_out=0x0002.
REQ-038 Entry 7 = 0x5555 with used[7]=0, no other match -> hit=0 at cycle 5; set used[7]=1 and repeat -> hit=1, idx_out=0x0080 at cycle 3.
REQ-039 abort at cycle 2 on a miss lookup -> state IDLE at cycle 3, no done, hit=0; a new start at cycle 4 completes normally; start pulsed at cycle 1 is ignored.
REQ-040 rst_n low at cycle 2 during SCAN -> all outputs 0 immediately, no done after release; start+abort together in IDLE -> no lookup starts.
